// File: rtl/serial_add_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done handshake plus data.
// Master drives start and operands; slave returns status and the held result.
interface serial_add_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;
  logic             carry;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, c, carry, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, c, carry, overflow
  );
endinterface

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder with carry-out and signed overflow; latency WIDTH cycles, one result per WIDTH+1.
// Backpressure: start is only sampled in IDLE or DONE; requests while busy are dropped.
module serial_add #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_add_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step;
  logic             w_fin;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_c;
  logic             r_carry;
  logic             r_ovf;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_fin  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One full adder, fed from the operand LSBs; the sum enters the result MSB.
  assign w_s   = r_a[0] ^ r_b[0] ^ r_cy;
  assign w_co  = (r_a[0] & r_b[0]) | (r_a[0] & r_cy) | (r_b[0] & r_cy);
  assign w_res = {w_s, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_c     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
      r_sum   <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_sum <= w_res;
      r_cy  <= w_co;
      r_cnt <= r_cnt + CW'(1);
      // Operand MSBs are shifted away by now, so the sign rule uses the copies taken at load.
      if (w_fin) begin
        r_c     <= w_res;
        r_carry <= w_co;
        r_ovf   <= (r_a_msb == r_b_msb) && (w_s != r_a_msb);
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.c        = r_c;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add: scoreboard of reference sums, latency and handshake checks.
module tb_serial_add;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(W)) bus();

  serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] c;
    logic         cy;
    logic         ov;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    exp_t e;
    s    = {1'b0, a} + {1'b0, b};
    e.c  = s[W-1:0];
    e.cy = s[W];
    e.ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  // Drives start for one edge; returns at the negedge after the accepting edge.
  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    if (push) sb.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   lat = 0;
    int   nb  = 0;
    exp_t e;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".busycycles"}, nb, exp_busy);
    check({tag, ".busy_at_done"}, {31'b0, bus.busy}, 0);
    check({tag, ".sb_pending"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".c"}, {16'b0, bus.c}, {16'b0, e.c});
      check({tag, ".carry"}, {31'b0, bus.carry}, {31'b0, e.cy});
      check({tag, ".ovf"}, {31'b0, bus.overflow}, {31'b0, e.ov});
    end
  endtask

  task automatic after_done(input string tag, input logic [W-1:0] held);
    @(negedge clk);
    check({tag, ".done_1cyc"}, {31'b0, bus.done}, 0);
    check({tag, ".c_hold"}, {16'b0, bus.c}, {16'b0, held});
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    pulse(a, b, 1'b1);
    wait_done(tag, W, W);
    after_done(tag, bus.c);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int ndone;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.busy", {31'b0, bus.busy}, 0);
    check("rst.done", {31'b0, bus.done}, 0);
    check("rst.c", {16'b0, bus.c}, 0);
    check("rst.carry", {31'b0, bus.carry}, 0);
    check("rst.ovf", {31'b0, bus.overflow}, 0);
    repeat (3) @(negedge clk);
    check("idle.busy", {31'b0, bus.busy}, 0);

    // Basic sums and flag boundaries
    op("sum10_5", 16'd10, 16'd5);
    op("sum20_30", 16'd20, 16'd30);
    op("sum999_1", 16'd999, 16'd1);
    op("pos_ovf", 16'd32767, 16'd1);
    op("wrap", 16'd65535, 16'd1);
    op("neg_ovf", 16'd32768, 16'd32768);
    op("inv_sub", 16'd65526, 16'd30);

    // Start during RUN is ignored
    pulse(16'd1, 16'd2, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd100;
    bus.b     = 16'd100;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored", W - 5, W - 5);
    after_done("ignored", 16'd3);

    // Back-to-back: start held high through DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd7;
    bus.b     = 16'd8;
    sb.push_back(model(16'd7, 16'd8));
    @(negedge clk);
    wait_done("b2b_first", W, W);
    sb.push_back(model(16'd7, 16'd8));
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_second", W, W);
    after_done("b2b_second", 16'd15);

    // Reset mid-operation
    pulse(16'd1000, 16'd1000, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", {31'b0, bus.busy}, 0);
    check("midrst.done", {31'b0, bus.done}, 0);
    check("midrst.c", {16'b0, bus.c}, 0);
    check("midrst.carry", {31'b0, bus.carry}, 0);
    check("midrst.ovf", {31'b0, bus.overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    op("after_rst", 16'd1, 16'd1);
    check("after_rst.c2", {16'b0, bus.c}, 2);

    // A few random operand pairs
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      op("rand", ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add.md
# serial_add

Bit-serial 16-bit adder that accepts two operands on a start pulse and returns their modulo-2^WIDTH sum, carry-out and signed overflow after WIDTH cycles. It is the inverse operation of the existing combinational `sub` block (a − b = c), so a + b recovers the minuend: serial_add(c, b) == a. It sits in the FPGA datapath where a small area matters more than latency, and it uses a start/busy/done handshake so a sequencer or bench can drive it.

## Interface
- WIDTH, 16, operand and result width in bits; legal range 2..32.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clears all state immediately.
- start  in  1  request; sampled on a rising edge only while not busy.
- a  in  WIDTH  operand A, unsigned or two's complement; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; c, carry and overflow are valid and updated.
- c  out  WIDTH  sum (a + b) mod 2^WIDTH; holds its value until the next completion.
- carry  out  1  unsigned carry-out of the MSB; holds its value like c.
- overflow  out  1  signed overflow: the operands have equal sign bits and the sum's sign bit differs; holds its value like c.

## Operation
- States are IDLE, RUN and DONE. A 2-bit state register plus a counter of ceil(log2 WIDTH) bits.
- IDLE: if start=1, capture a and b into shift registers, clear the internal carry and clear the counter, then go to RUN. Otherwise stay in IDLE.
- RUN: each cycle, add the LSBs of both shift registers and the internal carry (full adder).
  - Shift the sum bit into the MSB of the result shift register.
  - Shift both operand registers right and increment the counter.
  - On the cycle where counter == WIDTH−1, load c from the completed result register and the final sum bit, load carry from the final carry, load overflow from the sign-bit rule, then go to DONE.
- DONE: done=1 for this cycle only.
  - If start=1, accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start in RUN is ignored; the operands and result of the in-flight operation are unaffected.
- a and b may change at any time after acceptance without effect.
- Arithmetic wraps silently: c = (a + b) mod 2^WIDTH. No saturation.
- overflow is computed from the captured MSBs of a and b and the MSB of c.
- Reset value of every output is 0 (busy, done, c, carry, overflow). Internal state resets to IDLE with the counter and registers cleared.
- Reset asserted mid-operation aborts the operation. Outputs return to 0 at once, and no done is generated for the aborted operation.

## Timing
- start sampled high at edge k (state IDLE or DONE) means the operation is accepted at edge k.
- busy = 1 after edge k through edge k+WIDTH, i.e. for WIDTH cycles.
- done = 1 during the cycle after edge k+WIDTH, so latency from acceptance to the done pulse is WIDTH cycles (16 by default).
- c, carry and overflow change only at the edge that raises done. They are stable while done is high and afterwards.
- busy and done are never high in the same cycle.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- rst_n deassertion is assumed synchronised externally. The first start is honoured at the first rising edge with rst_n=1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → busy=0, done=0, c=0, carry=0, overflow=0, and the block stays idle with start=0.
- Basic sums, each pulsed separately:
  - a=10, b=5 → c=15, carry=0, overflow=0.
  - a=20, b=30 → c=50.
  - a=999, b=1 → c=1000.
  - In every case done pulses exactly 16 cycles after acceptance.
- Boundary flags:
  - a=32767, b=1 → c=32768, carry=0, overflow=1.
  - a=65535, b=1 → c=0, carry=1, overflow=0.
  - a=32768, b=32768 → c=0, carry=1, overflow=1.
- Inverse of `sub`: a=65526 (−10 from 20−30), b=30 → c=20, carry=1, overflow=0.
- Handshake:
  - Pulse start with a=1, b=2, then pulse start again 5 cycles later with a=100, b=100. The second start is ignored, and done gives c=3.
  - Hold start high through DONE with a=7, b=8 → the next operation is accepted back-to-back, and the second done arrives 17 cycles after the first with c=15.
- Reset mid-operation: start a=1000, b=1000, then drop rst_n at cycle 8 → all outputs go to 0 at once and no done follows. A fresh start a=1, b=1 then yields c=2 after 16 cycles.
